// File: rtl/if_fetch_stage.sv
// ---------------------------------------------------------------------------
// if_fetch_stage
//
// Instruction-fetch stage. Holds the program counter, reads the instruction
// word from a word-addressed instruction memory and presents the PC and the
// fetched word to the IF/OF latch. The PC advances by 4 per cycle, holds on a
// data interlock or after a hlt instruction, and is redirected by the execute
// stage on a taken branch. A load port fills the memory before a program runs.
//
// Parameters
//   IMEM_DEPTH      instruction memory size in 32-bit words (power of two, >= 2)
//   RESET_PC        PC value after reset (word-aligned)
//   NOP_INSTR       word returned for an out-of-range fetch
//   HLT_OPCODE      instr[31:27] value that halts fetch
//
// Ports
//   clk             clock; all state updates on the rising edge
//   rst_n           asynchronous active-low reset
//   isDataInterLock stall request: hold the PC
//   isBranchTaken   redirect request from execute (wins over a stall)
//   branchPC        redirect target; low two bits are ignored
//   imem_we         instruction memory write enable
//   imem_waddr      instruction memory write word index
//   imem_wdata      instruction memory write data
//   output_IF_PC    current PC (the PC register itself)
//   IF_instruction  instruction at the current PC, combinational read
//   IF_halted       fetch halted on a hlt instruction
//   IF_fetch_fault  sticky: a fetch beyond IMEM_DEPTH was attempted
//   IF_fetch_count  number of sequential PC advances since reset
// ---------------------------------------------------------------------------
module if_fetch_stage #(
  parameter int unsigned IMEM_DEPTH = 1024,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR  = 32'h6800_0000,
  parameter logic [4:0]  HLT_OPCODE = 5'b11111,
  localparam int unsigned AW        = $clog2(IMEM_DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          isDataInterLock,
  input  logic          isBranchTaken,
  input  logic [31:0]   branchPC,
  input  logic          imem_we,
  input  logic [AW-1:0] imem_waddr,
  input  logic [31:0]   imem_wdata,
  output logic [31:0]   output_IF_PC,
  output logic [31:0]   IF_instruction,
  output logic          IF_halted,
  output logic          IF_fetch_fault,
  output logic [31:0]   IF_fetch_count
);

  // Depth expressed at word-index width so the range compare is same-width.
  localparam logic [29:0] DEPTH_W = 30'(IMEM_DEPTH);

  logic [31:0] imem [IMEM_DEPTH];

  logic [31:0] pc_q, pc_d;
  logic        halted_q, halted_d;
  logic        fault_q, fault_d;
  logic [31:0] count_q, count_d;

  logic [29:0] word_idx;
  logic        in_range;
  logic [31:0] fetch_word;
  logic        is_hlt;

  // -------------------------------------------------------------------------
  // Instruction memory: synchronous write, asynchronous read, never reset.
  // A write to the word being fetched therefore shows only after the edge.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (imem_we) begin
      imem[imem_waddr] <= imem_wdata;
    end
  end

  assign word_idx   = pc_q[31:2];
  assign in_range   = (word_idx < DEPTH_W);
  assign fetch_word = in_range ? imem[word_idx[AW-1:0]] : NOP_INSTR;
  assign is_hlt     = (fetch_word[31:27] == HLT_OPCODE);

  // -------------------------------------------------------------------------
  // Next-state logic, in priority order: redirect, hold, halt, advance.
  // -------------------------------------------------------------------------
  always_comb begin
    pc_d     = pc_q;
    halted_d = halted_q;
    count_d  = count_q;
    // Any edge that sees an out-of-range fetch latches the fault for good.
    fault_d  = fault_q | ~in_range;

    if (isBranchTaken) begin
      // Masking (rather than slicing) forces word alignment of the target.
      pc_d     = branchPC & 32'hFFFF_FFFC;
      halted_d = 1'b0;
    end else if (halted_q || isDataInterLock) begin
      // Hold. A hlt seen under a stall is re-evaluated once it releases.
      pc_d = pc_q;
    end else if (is_hlt) begin
      // Stay on the hlt word so it keeps being presented downstream.
      halted_d = 1'b1;
    end else begin
      pc_d    = pc_q + 32'd4;
      count_d = count_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q     <= RESET_PC;
      halted_q <= 1'b0;
      fault_q  <= 1'b0;
      count_q  <= 32'd0;
    end else begin
      pc_q     <= pc_d;
      halted_q <= halted_d;
      fault_q  <= fault_d;
      count_q  <= count_d;
    end
  end

  assign output_IF_PC   = pc_q;
  assign IF_instruction = fetch_word;
  assign IF_halted      = halted_q;
  assign IF_fetch_fault = fault_q;
  assign IF_fetch_count = count_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_if_fetch_stage
//
// Directed bench for if_fetch_stage. Instance "dut" uses the default
// 1024-word memory; instance "dut_s" uses a 4-word memory to reach the
// out-of-range fetch path quickly. Inputs change 1 time unit after a rising
// edge and outputs are sampled at the same point, away from the edge.
// ---------------------------------------------------------------------------
module tb_if_fetch_stage;

  logic        clk;
  int          checks;
  int          failures;

  // Main instance signals
  logic        rst_n;
  logic        isDataInterLock;
  logic        isBranchTaken;
  logic [31:0] branchPC;
  logic        imem_we;
  logic [9:0]  imem_waddr;
  logic [31:0] imem_wdata;
  logic [31:0] output_IF_PC;
  logic [31:0] IF_instruction;
  logic        IF_halted;
  logic        IF_fetch_fault;
  logic [31:0] IF_fetch_count;

  // Small-memory instance signals
  logic        s_rst_n;
  logic        s_we;
  logic [1:0]  s_waddr;
  logic [31:0] s_wdata;
  logic [31:0] s_pc;
  logic [31:0] s_instr;
  logic        s_halted;
  logic        s_fault;
  logic [31:0] s_count;

  if_fetch_stage #(.IMEM_DEPTH(1024)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .isDataInterLock (isDataInterLock),
    .isBranchTaken   (isBranchTaken),
    .branchPC        (branchPC),
    .imem_we         (imem_we),
    .imem_waddr      (imem_waddr),
    .imem_wdata      (imem_wdata),
    .output_IF_PC    (output_IF_PC),
    .IF_instruction  (IF_instruction),
    .IF_halted       (IF_halted),
    .IF_fetch_fault  (IF_fetch_fault),
    .IF_fetch_count  (IF_fetch_count)
  );

  if_fetch_stage #(.IMEM_DEPTH(4)) dut_s (
    .clk             (clk),
    .rst_n           (s_rst_n),
    .isDataInterLock (1'b0),
    .isBranchTaken   (1'b0),
    .branchPC        (32'h0),
    .imem_we         (s_we),
    .imem_waddr      (s_waddr),
    .imem_wdata      (s_wdata),
    .output_IF_PC    (s_pc),
    .IF_instruction  (s_instr),
    .IF_halted       (s_halted),
    .IF_fetch_fault  (s_fault),
    .IF_fetch_count  (s_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // PC, instruction, halted, count of the main instance in one go.
  task automatic check_main(input string tag, input logic [31:0] pc,
                            input logic [31:0] ins, input logic h,
                            input logic [31:0] cnt);
    check({tag, ".pc"}, output_IF_PC, pc);
    check({tag, ".instr"}, IF_instruction, ins);
    check({tag, ".halted"}, {31'd0, IF_halted}, {31'd0, h});
    check({tag, ".count"}, IF_fetch_count, cnt);
    $display("step %-10s pc=%h instr=%h halted=%0b fault=%0b count=%0d",
             tag, output_IF_PC, IF_instruction, IF_halted, IF_fetch_fault, IF_fetch_count);
  endtask

  task automatic load(input logic [9:0] idx, input logic [31:0] w);
    imem_we    = 1'b1;
    imem_waddr = idx;
    imem_wdata = w;
    step();
    imem_we    = 1'b0;
  endtask

  task automatic load_s(input logic [1:0] idx, input logic [31:0] w);
    s_we    = 1'b1;
    s_waddr = idx;
    s_wdata = w;
    step();
    s_we    = 1'b0;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    s_rst_n = 1'b0;
    isDataInterLock = 1'b0;
    isBranchTaken = 1'b0;
    branchPC = 32'h0;
    imem_we = 1'b0;
    imem_waddr = '0;
    imem_wdata = '0;
    s_we = 1'b0;
    s_waddr = '0;
    s_wdata = '0;

    // Program load while held in reset.
    load(10'd0,  32'h1000_0000);
    load(10'd1,  32'h1000_0001);
    load(10'd2,  32'h1000_0002);
    load(10'd3,  32'h1000_0003);
    load(10'd4,  32'h1000_0004);
    load(10'd5,  32'h1000_0005);
    load(10'd16, 32'h1000_0010);
    load(10'd17, 32'h1000_0011);
    load_s(2'd0, 32'h2000_0000);
    load_s(2'd1, 32'h2000_0001);
    load_s(2'd2, 32'h2000_0002);
    load_s(2'd3, 32'h2000_0003);

    check_main("reset", 32'h0, 32'h1000_0000, 1'b0, 32'd0);
    check("reset.fault", {31'd0, IF_fetch_fault}, 32'd0);

    // Sequential run.
    rst_n = 1'b1;
    step(); check_main("seq1", 32'h4, 32'h1000_0001, 1'b0, 32'd1);
    step(); check_main("seq2", 32'h8, 32'h1000_0002, 1'b0, 32'd2);

    // Two-cycle interlock at PC 8.
    isDataInterLock = 1'b1;
    step(); check_main("stall1", 32'h8, 32'h1000_0002, 1'b0, 32'd2);
    step(); check_main("stall2", 32'h8, 32'h1000_0002, 1'b0, 32'd2);
    isDataInterLock = 1'b0;
    step(); check_main("release", 32'hC, 32'h1000_0003, 1'b0, 32'd3);

    // Branch and interlock together: branch wins, target low bits dropped.
    isBranchTaken = 1'b1;
    branchPC = 32'h0000_0043;
    isDataInterLock = 1'b1;
    step(); check_main("br_stall", 32'h40, 32'h1000_0010, 1'b0, 32'd3);
    isBranchTaken = 1'b0;
    isDataInterLock = 1'b0;

    // Plant hlt at index 5 while running, then restart from 0.
    imem_we = 1'b1; imem_waddr = 10'd5; imem_wdata = 32'hF800_0000;
    step(); check_main("run_wr", 32'h44, 32'h1000_0011, 1'b0, 32'd4);
    imem_we = 1'b0;
    isBranchTaken = 1'b1; branchPC = 32'h0;
    step(); check_main("br0", 32'h0, 32'h1000_0000, 1'b0, 32'd4);
    isBranchTaken = 1'b0;
    step(); step(); step(); step();
    check_main("to_c", 32'h10, 32'h1000_0004, 1'b0, 32'd8);
    step(); check_main("at_hlt", 32'h14, 32'hF800_0000, 1'b0, 32'd9);

    // hlt under a stall does not halt.
    isDataInterLock = 1'b1;
    step(); check_main("hlt_stall", 32'h14, 32'hF800_0000, 1'b0, 32'd9);
    isDataInterLock = 1'b0;
    step(); check_main("halt", 32'h14, 32'hF800_0000, 1'b1, 32'd9);
    step(); step(); step(); step();
    check_main("halt_hold", 32'h14, 32'hF800_0000, 1'b1, 32'd9);

    // Redirect leaves halt.
    isBranchTaken = 1'b1; branchPC = 32'h0;
    step(); check_main("unhalt", 32'h0, 32'h1000_0000, 1'b0, 32'd9);
    isBranchTaken = 1'b0;
    step(); step();
    check_main("pc8", 32'h8, 32'h1000_0002, 1'b0, 32'd11);

    // Write to the fetched word: old before the edge, new after.
    isDataInterLock = 1'b1;
    imem_we = 1'b1; imem_waddr = 10'd2; imem_wdata = 32'hABCD_0000;
    #1;
    check("wr_before", IF_instruction, 32'h1000_0002);
    step(); check_main("wr_after", 32'h8, 32'hABCD_0000, 1'b0, 32'd11);
    imem_we = 1'b0;
    isDataInterLock = 1'b0;

    // Out-of-range fetch at the top of the address space, then wrap to 0.
    isBranchTaken = 1'b1; branchPC = 32'hFFFF_FFFC;
    step(); check_main("top", 32'hFFFF_FFFC, 32'h6800_0000, 1'b0, 32'd11);
    check("top.fault", {31'd0, IF_fetch_fault}, 32'd0);
    isBranchTaken = 1'b0;
    step(); check_main("wrap", 32'h0, 32'h1000_0000, 1'b0, 32'd12);
    check("wrap.fault", {31'd0, IF_fetch_fault}, 32'd1);

    // Reset between edges overrides a pending redirect and acts at once.
    isBranchTaken = 1'b1; branchPC = 32'h40;
    #2;
    rst_n = 1'b0;
    #1;
    check_main("async_rst", 32'h0, 32'h1000_0000, 1'b0, 32'd0);
    check("async_rst.fault", {31'd0, IF_fetch_fault}, 32'd0);
    step(); check_main("rst_hold", 32'h0, 32'h1000_0000, 1'b0, 32'd0);
    isBranchTaken = 1'b0;
    rst_n = 1'b1;

    // Small memory: run past the end.
    s_rst_n = 1'b1;
    step(); step(); step(); step();
    check("s.pc10", s_pc, 32'h10);
    check("s.nop", s_instr, 32'h6800_0000);
    check("s.nofault", {31'd0, s_fault}, 32'd0);
    $display("step %-10s pc=%h instr=%h fault=%0b count=%0d", "s_edge", s_pc, s_instr, s_fault, s_count);
    step();
    check("s.fault", {31'd0, s_fault}, 32'd1);
    check("s.pc14", s_pc, 32'h14);
    check("s.count", s_count, 32'd5);
    $display("step %-10s pc=%h instr=%h fault=%0b count=%0d", "s_fault", s_pc, s_instr, s_fault, s_count);
    #2;
    s_rst_n = 1'b0;
    #1;
    check("s.rst.pc", s_pc, 32'h0);
    check("s.rst.instr", s_instr, 32'h2000_0000);
    check("s.rst.fault", {31'd0, s_fault}, 32'd0);
    check("s.rst.halted", {31'd0, s_halted}, 32'd0);
    check("s.rst.count", s_count, 32'd0);
    $display("step %-10s pc=%h instr=%h fault=%0b count=%0d", "s_rst", s_pc, s_instr, s_fault, s_count);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/if_fetch_stage.md
# if_fetch_stage

Instruction-fetch stage of the pipelined processor. It holds the program counter, reads the instruction word from a word-addressed instruction memory, and presents `output_IF_PC` and `IF_instruction` to the IF/OF latch. It advances the PC by 4 each cycle, holds on data interlock or halt, and redirects to the branch target from the execute stage. A load port fills the instruction memory before the program runs.

## Interface
- `IMEM_DEPTH`, 1024: instruction memory size in 32-bit words; power of two, at least 2.
- `RESET_PC`, 32'h0000_0000: PC value after reset; word-aligned.
- `NOP_INSTR`, 32'h6800_0000: word returned for an out-of-range fetch.
- `HLT_OPCODE`, 5'b11111: value of `instr[31:27]` that halts fetch.
- `clk`  in  1  single clock; PC, memory, flags and counter update on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `isDataInterLock`  in  1  stall request: hold the PC.
- `isBranchTaken`  in  1  redirect request from execute.
- `branchPC`  in  32  redirect target.
- `imem_we`  in  1  instruction memory write enable.
- `imem_waddr`  in  $clog2(IMEM_DEPTH)  write word index.
- `imem_wdata`  in  32  write data.
- `output_IF_PC`  out  32  current PC; equals the PC register.
- `IF_instruction`  out  32  instruction at the current PC; combinational read.
- `IF_halted`  out  1  fetch halted on a hlt instruction.
- `IF_fetch_fault`  out  1  sticky flag: a fetch was attempted beyond `IMEM_DEPTH`.
- `IF_fetch_count`  out  32  number of sequential PC advances since reset.

## Operation
- Word index is `PC[31:2]`. The fetch is out of range when the index is ≥ `IMEM_DEPTH`.
  - In range: `IF_instruction` = `imem[index]`.
  - Out of range: `IF_instruction` = `NOP_INSTR`, and the next rising edge sets `IF_fetch_fault`. The flag clears only on reset.
- PC update on each rising edge, in priority order:
  1. `isBranchTaken`: PC ← `{branchPC[31:2],2'b00}` (low bits forced to zero); `IF_halted` ← 0; counter unchanged.
  2. `IF_halted` or `isDataInterLock`: PC holds; counter unchanged.
  3. Current instruction has `IF_instruction[31:27]` == `HLT_OPCODE`: `IF_halted` ← 1; PC holds at the hlt address; counter unchanged.
  4. Otherwise: PC ← PC + 4, modulo 2^32 (0xFFFF_FFFC wraps to 0); `IF_fetch_count` ← count + 1, wrapping at 2^32.
- Halt rules:
  - While halted, `IF_instruction` keeps showing the hlt word.
  - Only a branch redirect or reset leaves the halted state. This lets a speculatively fetched hlt be squashed.
  - A hlt seen while `isDataInterLock` = 1 does not halt; it is re-evaluated after the stall releases.
- Memory:
  - Writes are synchronous on the rising edge when `imem_we` = 1.
  - Reads are asynchronous.
  - A write to the currently fetched index shows on `IF_instruction` only after that edge.
  - Memory contents are not reset.
  - Writes are permitted while running; the program loader keeps `rst_n` low during the load.

## Timing
- Reset (`rst_n` low, takes effect immediately, without waiting for a clock edge): PC = `RESET_PC`, `IF_halted` = 0, `IF_fetch_fault` = 0, `IF_fetch_count` = 0. Therefore `output_IF_PC` = `RESET_PC` and `IF_instruction` = the word at `RESET_PC`.
- Reset asserted mid-operation clears all state at once and overrides any pending redirect. The first advance happens at the first rising edge after `rst_n` goes high.
- Latency: a redirect or advance is visible on `output_IF_PC` and `IF_instruction` immediately after the rising edge; there are zero wait states.
- The downstream latch samples on the falling edge, so PC, memory read and muxing must settle within half a clock period.
- `isDataInterLock` and `isBranchTaken` are sampled on the rising edge. When both are high in the same cycle, the branch wins.
- Branch interlock and NOP insertion happen in the IF/OF latch, not in this block. This block only redirects the PC.

## Test plan
- Load words 0x10000000, 0x10000001, 0x10000002 at indices 0–2, reset, run 3 cycles -> `output_IF_PC` reads 0, 4, 8, 12; `IF_fetch_count` = 3.
- Hold `isDataInterLock` = 1 for 2 cycles at PC = 8 -> PC stays 8 and the count is frozen; after release, the next edge gives PC = 12.
- Assert `isBranchTaken` = 1 with `branchPC` = 0x0000_0043 and `isDataInterLock` = 1 in the same cycle -> PC = 0x40; count unchanged.
- Place 0xF8000000 at index 5 -> PC stops at 0x14, `IF_halted` = 1, and 4 further cycles leave PC unchanged. Then a branch to 0x0 -> `IF_halted` = 0, PC = 0.
- With `IMEM_DEPTH` = 4, run to PC = 0x10 -> `IF_instruction` = 0x68000000 and `IF_fetch_fault` = 1 after the next edge. Assert `rst_n` = 0 between clock edges -> all outputs return to reset values immediately.
- Write `imem[2]` = 0xABCD0000 while PC = 8 -> `IF_instruction` shows the old word before the edge and 0xABCD0000 after it.
